csr_file: RTL and testbench

//   Machine-mode CSR register file; consumes the CSR control fields produced by the control unit.

---
 rtl/csr_file.sv | 180 ++++++++++++++++++
 tb/tb_csr_file.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSRRW/S/C (+immediate forms), trap/mret state, and
// 64-bit mcycle/minstret counters with read-only user aliases.
module csr_file #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_addr,
  input  logic            csr_write_enable,
  input  logic [1:0]      csr_op,
  input  logic [2:0]      csr_funct3,
  input  logic [4:0]      csr_imm,
  input  logic [4:0]      rs1_idx,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            instr_retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] epc,
  output logic            mie_out
);

  localparam int unsigned CW = 2 * XLEN;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {OP_RW, OP_RS, OP_RC, OP_NONE} csr_alu_e;

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [CW-1:0]   mcycle_q, mcycle_d, minstret_q, minstret_d;

  csr_alu_e        alu_op;
  logic [XLEN-1:0] src, old_val, wdata;
  logic            src_zero, implemented, wr_req, wr_en;

  // Decode the operation, its source operand, and whether the source is x0/uimm 0.
  always_comb begin
    alu_op   = OP_NONE;
    src      = rs1_data;
    src_zero = (rs1_idx == 5'd0);
    unique case (csr_op)
      2'b00: alu_op = OP_RW;
      2'b01: alu_op = OP_RS;
      2'b10: alu_op = OP_RC;
      default: begin
        src      = {{(XLEN-5){1'b0}}, csr_imm};
        src_zero = (csr_imm == 5'd0);
        case (csr_funct3)
          3'b101:  alu_op = OP_RW;
          3'b110:  alu_op = OP_RS;
          3'b111:  alu_op = OP_RC;
          default: alu_op = OP_NONE;
        endcase
      end
    endcase
  end

  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS: begin
        old_val[3] = mie_q;
        old_val[7] = mpie_q;
      end
      ADDR_MTVEC:                    old_val = mtvec_q;
      ADDR_MSCRATCH:                 old_val = mscratch_q;
      ADDR_MEPC:                     old_val = mepc_q;
      ADDR_MCAUSE:                   old_val = mcause_q;
      ADDR_MCYCLE,   ADDR_CYCLE:     old_val = mcycle_q[XLEN-1:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:    old_val = mcycle_q[CW-1:XLEN];
      ADDR_MINSTRET, ADDR_INSTRET:   old_val = minstret_q[XLEN-1:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: old_val = minstret_q[CW-1:XLEN];
      default:                       implemented = 1'b0;
    endcase
  end

  always_comb begin
    unique case (alu_op)
      OP_RW:   wdata = src;
      OP_RS:   wdata = old_val | src;
      OP_RC:   wdata = old_val & ~src;
      default: wdata = old_val;
    endcase
  end

  // Set/clear with a zero source never writes, so reading a 0xCxx alias stays legal.
  assign wr_req      = csr_write_enable && (alu_op != OP_NONE) && !(alu_op != OP_RW && src_zero);
  assign csr_illegal = csr_write_enable && (!implemented || (wr_req && csr_addr[11:10] == 2'b11));
  assign wr_en       = wr_req && !csr_illegal;

  always_comb begin
    // NOTE: every _d starts from its _q, so no branch below can infer a latch.
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + CW'(1);
    minstret_d = minstret_q + CW'(instr_retire);
    if (trap_valid) begin
      mepc_d   = trap_pc & ~XLEN'(3);
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else begin
      if (wr_en) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mie_d  = wdata[3];
            mpie_d = wdata[7];
          end
          ADDR_MTVEC:     mtvec_d    = wdata & ~XLEN'(3);
          ADDR_MSCRATCH:  mscratch_d = wdata;
          ADDR_MEPC:      mepc_d     = wdata & ~XLEN'(3);
          ADDR_MCAUSE:    mcause_d   = wdata;
          ADDR_MCYCLE:    mcycle_d   = {mcycle_q[CW-1:XLEN], wdata};
          ADDR_MCYCLEH:   mcycle_d   = {wdata, mcycle_q[XLEN-1:0]};
          ADDR_MINSTRET:  minstret_d = {minstret_q[CW-1:XLEN], wdata};
          ADDR_MINSTRETH: minstret_d = {wdata, minstret_q[XLEN-1:0]};
          default: ;
        endcase
      end
      // mret after the write so a same-cycle mstatus write is discarded.
      if (mret) begin
        mie_d  = mpie_q;
        mpie_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign csr_rdata   = old_val;
  assign trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
  assign epc         = mepc_q;
  assign mie_out     = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: driver queues expected responses per CSR
// instruction, a negedge monitor pops and compares them.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] csr_addr = '0;
  logic        csr_write_enable = 1'b0;
  logic [1:0]  csr_op = '0;
  logic [2:0]  csr_funct3 = '0;
  logic [4:0]  csr_imm = '0;
  logic [4:0]  rs1_idx = '0;
  logic [31:0] rs1_data = '0;
  logic        instr_retire = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic        mret = 1'b0;
  logic [31:0] csr_rdata, trap_vector, epc;
  logic        csr_illegal, mie_out;

  csr_file #(.XLEN(32), .MTVEC_RST(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_write_enable(csr_write_enable),
    .csr_op(csr_op), .csr_funct3(csr_funct3), .csr_imm(csr_imm), .rs1_idx(rs1_idx),
    .rs1_data(rs1_data), .instr_retire(instr_retire), .trap_valid(trap_valid),
    .trap_pc(trap_pc), .trap_cause(trap_cause), .mret(mret), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .trap_vector(trap_vector), .epc(epc), .mie_out(mie_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] rd;
    logic        ill;
    bit          chk_aux;
    logic [31:0] tvec;
    logic [31:0] epc;
    logic        mie;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] cyc_m;
  bit          aux_en = 1'b0;
  logic [31:0] aux_tvec, aux_epc;
  logic        aux_mie;
  logic [31:0] lo_saved;

  // Reference cycle count: cycles elapsed since the last reset edge.
  always @(posedge clk) cyc_m <= !rst_n ? 64'd0 : cyc_m + 64'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (csr_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rdata %h with no expectation queued", csr_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_rd) check({mon_e.name, ".rdata"}, csr_rdata, mon_e.rd);
        check({mon_e.name, ".illegal"}, {31'b0, csr_illegal}, {31'b0, mon_e.ill});
        if (mon_e.chk_aux) begin
          check({mon_e.name, ".trap_vector"}, trap_vector, mon_e.tvec);
          check({mon_e.name, ".epc"}, epc, mon_e.epc);
          check({mon_e.name, ".mie"}, {31'b0, mie_out}, {31'b0, mon_e.mie});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rst_n            = 1'b1;
    csr_write_enable = 1'b0;
    trap_valid       = 1'b0;
    mret             = 1'b0;
    instr_retire     = 1'b0;
  endtask

  task automatic set_aux(input logic [31:0] t, input logic [31:0] e, input logic m);
    aux_en = 1'b1; aux_tvec = t; aux_epc = e; aux_mie = m;
  endtask

  task automatic instr(input logic [11:0] addr, input logic [1:0] op, input logic [2:0] f3,
                       input logic [4:0] imm, input logic [4:0] idx, input logic [31:0] data,
                       input string name, input bit chk_rd, input logic [31:0] rd, input logic ill);
    exp_t e;
    csr_addr = addr; csr_op = op; csr_funct3 = f3; csr_imm = imm;
    rs1_idx = idx; rs1_data = data; csr_write_enable = 1'b1;
    e.name = name; e.chk_rd = chk_rd; e.rd = rd; e.ill = ill;
    e.chk_aux = aux_en; e.tvec = aux_tvec; e.epc = aux_epc; e.mie = aux_mie;
    exp_q.push_back(e);
    aux_en = 1'b0;
  endtask

  // CSRRS with rs1=x0 and all-ones data: a pure read that must not write.
  task automatic rd(input logic [11:0] addr, input string name, input logic [31:0] exp);
    instr(addr, 2'b01, 3'b000, 5'd0, 5'd0, 32'hFFFF_FFFF, name, 1'b1, exp, 1'b0);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data, input string name,
                    input logic [31:0] exp_old);
    instr(addr, 2'b00, 3'b000, 5'd0, 5'd1, data, name, 1'b1, exp_old, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    set_aux(32'h0, 32'h0, 1'b0); rd(12'h300, "rst_mstatus", 32'h0);
    step(); rd(12'hB00, "rst_mcycle", cyc_m[31:0]);
    step(); rd(12'h305, "rst_mtvec", 32'h0);
    step(); rd(12'h342, "rst_mcause", 32'h0);

    step(); instr(12'h340, 2'b00, 3'b000, 5'd0, 5'd5, 32'hDEAD_BEEF, "rw_mscratch", 1'b1, 32'h0, 1'b0);
    step(); rd(12'h340, "rd_mscratch", 32'hDEAD_BEEF);
    step(); wr(12'h340, 32'h0000_F0F0, "rw_f0f0", 32'hDEAD_BEEF);
    step(); rd(12'h340, "rs_x0_nowrite", 32'h0000_F0F0);
    step(); instr(12'h340, 2'b11, 3'b111, 5'h10, 5'd0, 32'h0, "rci_10", 1'b1, 32'h0000_F0F0, 1'b0);
    step(); instr(12'h340, 2'b11, 3'b110, 5'h00, 5'd7, 32'hFFFF_FFFF, "rsi_0_nowrite", 1'b1, 32'h0000_F0E0, 1'b0);
    step(); instr(12'h340, 2'b01, 3'b000, 5'd0, 5'd3, 32'h0000_000F, "rs_0f", 1'b1, 32'h0000_F0E0, 1'b0);
    step(); instr(12'h340, 2'b11, 3'b001, 5'h1F, 5'd1, 32'hFFFF_FFFF, "imm_bad_f3", 1'b1, 32'h0000_F0EF, 1'b0);
    step(); instr(12'h340, 2'b11, 3'b101, 5'h00, 5'd0, 32'hFFFF_FFFF, "rwi_0", 1'b1, 32'h0000_F0EF, 1'b0);
    step(); rd(12'h340, "rwi_0_wrote", 32'h0);

    step(); wr(12'h305, 32'h8000_0103, "rw_mtvec", 32'h0);
    step(); set_aux(32'h8000_0100, 32'h0, 1'b0); rd(12'h305, "rd_mtvec", 32'h8000_0100);
    step(); instr(12'hC00, 2'b00, 3'b000, 5'd0, 5'd2, 32'h0000_1234, "rw_cycle_ro", 1'b1, cyc_m[31:0], 1'b1);
    step(); rd(12'hC00, "rd_cycle", cyc_m[31:0]);
    step(); rd(12'hC80, "rd_cycleh", cyc_m[63:32]);
    step(); instr(12'h7C0, 2'b01, 3'b000, 5'd0, 5'd0, 32'h0, "unimpl", 1'b1, 32'h0, 1'b1);
    step(); rd(12'hC02, "rd_instret0", 32'h0);
    repeat (3) begin step(); instr_retire = 1'b1; end
    step(); rd(12'hB02, "rd_minstret3", 32'd3);
    step(); rd(12'hC82, "rd_instreth", 32'h0);

    step(); wr(12'h300, 32'hFFFF_FFFF, "rw_mstatus_all", 32'h0);
    step(); set_aux(32'h8000_0100, 32'h0, 1'b1); rd(12'h300, "mstatus_mask", 32'h0000_0088);
    step(); instr(12'h300, 2'b10, 3'b000, 5'd0, 5'd1, 32'h0000_0080, "rc_mpie", 1'b1, 32'h0000_0088, 1'b0);
    step(); rd(12'h300, "mstatus_mie_only", 32'h0000_0008);
    step(); trap_valid = 1'b1; trap_pc = 32'h104; trap_cause = 32'd11;
    wr(12'h340, 32'h55, "trap_with_write", 32'h0);
    step(); set_aux(32'h8000_0100, 32'h104, 1'b0); rd(12'h300, "post_trap_mstatus", 32'h0000_0080);
    step(); mret = 1'b1; wr(12'h340, 32'h77, "mret_with_write", 32'h0);
    step(); set_aux(32'h8000_0100, 32'h104, 1'b1); rd(12'h300, "post_mret_mstatus", 32'h0000_0088);
    step(); rd(12'h342, "trap_mcause", 32'd11);
    step(); rd(12'h340, "mret_write_kept", 32'h77);
    step(); trap_valid = 1'b1; trap_pc = 32'h207; trap_cause = 32'd2;
    step(); mret = 1'b1; wr(12'h300, 32'h0, "mret_drops_mstatus_wr", 32'h0000_0080);
    step(); set_aux(32'h8000_0100, 32'h204, 1'b1); rd(12'h300, "mret_mstatus", 32'h0000_0088);
    step(); wr(12'h341, 32'h0000_1003, "rw_mepc", 32'h204);
    step(); set_aux(32'h8000_0100, 32'h1000, 1'b1); rd(12'h341, "mepc_mask", 32'h0000_1000);
    step(); wr(12'h342, 32'h8000_000B, "rw_mcause", 32'd2);
    step(); rd(12'h342, "mcause_full", 32'h8000_000B);

    step(); lo_saved = cyc_m[31:0]; wr(12'hB80, 32'h5, "rw_mcycleh", cyc_m[63:32]);
    step(); wr(12'hB00, 32'hFFFF_FFFF, "rw_mcycle_lo", lo_saved);
    step(); rd(12'hB00, "mcycle_write_wins", 32'hFFFF_FFFF);
    step(); rd(12'hB80, "mcycle_carry", 32'h6);
    step(); rd(12'hB00, "mcycle_lo_after_carry", 32'h1);
    step(); wr(12'hB80, 32'hFFFF_FFFF, "rw_mcycleh_max", 32'h6);
    step(); wr(12'hB00, 32'hFFFF_FFFE, "rw_mcycle_lo_max", 32'h2);
    step(); rd(12'hB00, "mcycle_lo_fffe", 32'hFFFF_FFFE);
    step(); rd(12'hB80, "mcycle_hi_ffff", 32'hFFFF_FFFF);
    step(); rd(12'hB00, "mcycle_wrap_lo", 32'h0);
    step(); rd(12'hB80, "mcycle_wrap_hi", 32'h0);
    step(); instr_retire = 1'b1; wr(12'hB02, 32'h100, "rw_minstret_retire", 32'd3);
    step(); instr_retire = 1'b1; rd(12'hB02, "minstret_write_wins", 32'h100);
    step(); rd(12'hB02, "minstret_inc", 32'h101);

    step(); rst_n = 1'b0; trap_valid = 1'b1; instr_retire = 1'b1; mret = 1'b0;
    trap_pc = 32'h300; trap_cause = 32'd5;
    wr(12'h340, 32'h99, "reset_cycle_write", 32'h77);
    step(); set_aux(32'h0, 32'h0, 1'b0); rd(12'h300, "rst2_mstatus", 32'h0);
    step(); rd(12'h305, "rst2_mtvec", 32'h0);
    step(); rd(12'h340, "rst2_mscratch", 32'h0);
    step(); rd(12'h341, "rst2_mepc", 32'h0);
    step(); rd(12'h342, "rst2_mcause", 32'h0);
    step(); rd(12'hB00, "rst2_mcycle", cyc_m[31:0]);
    step(); rd(12'hB80, "rst2_mcycleh", 32'h0);
    step(); rd(12'hB02, "rst2_minstret", 32'h0);
    step(); rd(12'hB82, "rst2_minstreth", 32'h0);
    step();
    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
